// File: rtl/present_pkg.sv
// present_pkg: shared types and round primitives for the iterative PRESENT core.
//   - state_e    : core FSM states
//   - sbox/inv_sbox, perm/inv_perm : 4-bit S-box and 64-bit bit permutation
//   - key_upd80/128, key_inv_upd80/128 : forward and inverse key-schedule steps
package present_pkg;

  localparam int unsigned BLK_W = 64;
  localparam int unsigned RND_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYFWD = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Nibble x of each table holds f(x).
  localparam logic [63:0] SBOX_LUT     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX_LUT = 64'hA970364BD21C8FE5;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_LUT[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_LUT[{x, 2'b00} +: 4];
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays put.
  function automatic logic [BLK_W-1:0] perm(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) o[6'((16 * i) % 63)] = s[i];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] inv_perm(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) o[i] = s[6'((16 * i) % 63)];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [79:0] key_upd80(input logic [79:0] k, input logic [RND_W-1:0] r);
    logic [79:0] t;
    t         = {k[18:0], k[79:19]};
    t[79:76]  = sbox(t[79:76]);
    t[19:15]  = t[19:15] ^ r;
    return t;
  endfunction

  function automatic logic [127:0] key_upd128(input logic [127:0] k, input logic [RND_W-1:0] r);
    logic [127:0] t;
    t           = {k[66:0], k[127:67]};
    t[127:124]  = sbox(t[127:124]);
    t[123:120]  = sbox(t[123:120]);
    t[66:62]    = t[66:62] ^ r;
    return t;
  endfunction

  function automatic logic [79:0] key_inv_upd80(input logic [79:0] k, input logic [RND_W-1:0] r);
    logic [79:0] t;
    t         = k;
    t[19:15]  = t[19:15] ^ r;
    t[79:76]  = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  function automatic logic [127:0] key_inv_upd128(input logic [127:0] k, input logic [RND_W-1:0] r);
    logic [127:0] t;
    t           = k;
    t[66:62]    = t[66:62] ^ r;
    t[127:124]  = inv_sbox(t[127:124]);
    t[123:120]  = inv_sbox(t[123:120]);
    return {t[60:0], t[127:61]};
  endfunction

endpackage

// File: rtl/present_key_sched.sv
// present_key_sched: key register plus forward (and optionally inverse) update.
// Ports: clk, rst_n, load_i/key_i (load new key), fwd_en_i (apply forward update),
//        inv_en_i (inverse update, only with PRESENT_DECRYPT_EN), rnd_i (round number),
//        top64_o (current round key), fwd_top64_o / inv_top64_o (round key after update).
// Macro: PRESENT_DECRYPT_EN builds the inverse update path.
module present_key_sched
  import present_pkg::*;
#(
  parameter int unsigned KEY_W = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             fwd_en_i,
`ifdef PRESENT_DECRYPT_EN
  input  logic             inv_en_i,
  output logic [BLK_W-1:0] inv_top64_o,
`endif
  input  logic [RND_W-1:0] rnd_i,
  output logic [BLK_W-1:0] top64_o,
  output logic [BLK_W-1:0] fwd_top64_o
);

  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] fwd_key;
`ifdef PRESENT_DECRYPT_EN
  logic [KEY_W-1:0] inv_key;
`endif

  // Update flavour fixed by key width at elaboration.
  if (KEY_W == 80) begin : g_k80
    assign fwd_key = key_upd80(key_q, rnd_i);
`ifdef PRESENT_DECRYPT_EN
    assign inv_key = key_inv_upd80(key_q, rnd_i);
`endif
  end else if (KEY_W == 128) begin : g_k128
    assign fwd_key = key_upd128(key_q, rnd_i);
`ifdef PRESENT_DECRYPT_EN
    assign inv_key = key_inv_upd128(key_q, rnd_i);
`endif
  end else begin : g_bad_key_w
    $error("present_key_sched: KEY_W must be 80 or 128");
  end

  always_comb begin
    key_d = key_q;
    if (load_i)        key_d = key_i;
    else if (fwd_en_i) key_d = fwd_key;
`ifdef PRESENT_DECRYPT_EN
    else if (inv_en_i) key_d = inv_key;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_q <= '0;
    else        key_q <= key_d;
  end

  assign top64_o     = key_q[KEY_W-1 -: BLK_W];
  assign fwd_top64_o = fwd_key[KEY_W-1 -: BLK_W];
`ifdef PRESENT_DECRYPT_EN
  assign inv_top64_o = inv_key[KEY_W-1 -: BLK_W];
`endif

endmodule

// File: rtl/present_iter_core.sv
// present_iter_core: iterative PRESENT engine, SBOX_PAR S-boxes per cycle,
// 16/SBOX_PAR cycles per round, valid/ready handshake on request and result.
// Ports: clk, rst_n; in_valid/in_ready/in_decrypt/key/pt (request);
//        out_valid/out_ready/ct (result, ct registered); busy (not idle).
// Macro: PRESENT_DECRYPT_EN adds decryption (KEYFWD pre-pass + inverse rounds).
module present_iter_core
  import present_pkg::*;
#(
  parameter int unsigned KEY_W    = 80,
  parameter int unsigned ROUNDS   = 31,
  parameter int unsigned SBOX_PAR = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_decrypt,
  input  logic [KEY_W-1:0] key,
  input  logic [63:0]      pt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      ct,
  output logic             busy
);

  localparam int unsigned     C      = 16 / SBOX_PAR;
  localparam logic [1:0]       J_LAST = 2'(C - 1);
  localparam logic [RND_W-1:0] R_LAST = RND_W'(ROUNDS);

  if (ROUNDS == 0 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_iter_core: ROUNDS must be 1..31");
  end
  if (SBOX_PAR != 4 && SBOX_PAR != 8 && SBOX_PAR != 16) begin : g_bad_par
    $error("present_iter_core: SBOX_PAR must be 4, 8 or 16");
  end

  state_e           state_q, state_d;
  logic [RND_W-1:0] r_q, r_d;
  logic [1:0]       j_q, j_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] ct_q, ct_d;
  logic             out_valid_q, out_valid_d;
  logic             key_load, key_fwd;
  logic [BLK_W-1:0] rkey, fwd_top;
  logic [BLK_W-1:0] enc_sub, enc_perm;
`ifdef PRESENT_DECRYPT_EN
  logic             dec_q, dec_d;
  logic             key_inv;
  logic [BLK_W-1:0] inv_top;
  logic [BLK_W-1:0] dec_src, dec_sub;
`else
  logic             unused_decrypt;
  assign unused_decrypt = in_decrypt;
`endif

  present_key_sched #(.KEY_W(KEY_W)) u_key_sched (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (key_load),
    .key_i       (key),
    .fwd_en_i    (key_fwd),
`ifdef PRESENT_DECRYPT_EN
    .inv_en_i    (key_inv),
    .inv_top64_o (inv_top),
`endif
    .rnd_i       (r_q),
    .top64_o     (rkey),
    .fwd_top64_o (fwd_top)
  );

  // Encrypt sub-step: key-add and substitute nibble group j, permute the full result.
  always_comb begin
    enc_sub = blk_q;
    for (int i = 0; i < 16; i++) begin
      if (2'(i / SBOX_PAR) == j_q) enc_sub[4*i +: 4] = sbox(blk_q[4*i +: 4] ^ rkey[4*i +: 4]);
    end
    enc_perm = perm(enc_sub);
  end

`ifdef PRESENT_DECRYPT_EN
  // Decrypt sub-step: inverse-permute on entry to the round, then inverse S-box group j.
  always_comb begin
    dec_src = (j_q == 2'd0) ? inv_perm(blk_q) : blk_q;
    dec_sub = dec_src;
    for (int i = 0; i < 16; i++) begin
      if (2'(i / SBOX_PAR) == j_q) dec_sub[4*i +: 4] = inv_sbox(dec_src[4*i +: 4]);
    end
  end
`endif

  // Next-state and control.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    j_d         = j_q;
    blk_d       = blk_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;
    key_load    = 1'b0;
    key_fwd     = 1'b0;
`ifdef PRESENT_DECRYPT_EN
    dec_d       = dec_q;
    key_inv     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d    = pt;
          key_load = 1'b1;
          r_d      = RND_W'(1);
          j_d      = 2'd0;
`ifdef PRESENT_DECRYPT_EN
          dec_d    = in_decrypt;
          state_d  = in_decrypt ? ST_KEYFWD : ST_ROUND;
`else
          state_d  = ST_ROUND;
`endif
        end
      end
`ifdef PRESENT_DECRYPT_EN
      // Walk the schedule forward to K_{ROUNDS+1}, then strip the final whitening key.
      ST_KEYFWD: begin
        key_fwd = 1'b1;
        r_d     = r_q + RND_W'(1);
        if (r_q == R_LAST) begin
          blk_d   = blk_q ^ fwd_top;
          r_d     = R_LAST;
          state_d = ST_ROUND;
        end
      end
`endif
      ST_ROUND: begin
`ifdef PRESENT_DECRYPT_EN
        if (dec_q) begin
          if (j_q == J_LAST) begin
            j_d     = 2'd0;
            key_inv = 1'b1;
            r_d     = r_q - RND_W'(1);
            blk_d   = dec_sub ^ inv_top;
            if (r_q == RND_W'(1)) begin
              ct_d        = dec_sub ^ inv_top;
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
            end
          end else begin
            blk_d = dec_sub;
            j_d   = j_q + 2'd1;
          end
        end else
`endif
        begin
          if (j_q == J_LAST) begin
            j_d     = 2'd0;
            key_fwd = 1'b1;
            r_d     = r_q + RND_W'(1);
            blk_d   = enc_perm;
            if (r_q == R_LAST) begin
              ct_d        = enc_perm ^ fwd_top;
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
            end
          end else begin
            blk_d = enc_sub;
            j_d   = j_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      j_q         <= '0;
      blk_q       <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      j_q         <= j_d;
      blk_q       <= blk_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
`ifdef PRESENT_DECRYPT_EN
      dec_q       <= dec_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign ct        = ct_q;

endmodule

// File: tb/tb_present_iter_core.sv
// tb_present_iter_core: directed checks of present_iter_core with known PRESENT vectors
// on three configurations (80-bit/16 S-boxes, 80-bit/4 S-boxes, 128-bit/16 S-boxes).
module tb_present_iter_core;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid_v, in_ready_v, out_valid_v, busy_v;
  logic         in_decrypt;
  logic         out_ready;
  logic [127:0] key_bus;
  logic [63:0]  pt_bus;
  logic [63:0]  ct_a [3];
  int           n_checks;
  int           n_fail;

  localparam logic [127:0] K0   = 128'h0;
  localparam logic [127:0] KF80 = 128'h0000_0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0]  P0   = 64'h0;
  localparam logic [63:0]  PF   = 64'hFFFF_FFFF_FFFF_FFFF;

  present_iter_core #(.KEY_W(80), .ROUNDS(31), .SBOX_PAR(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_decrypt(in_decrypt), .key(key_bus[79:0]), .pt(pt_bus), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .ct(ct_a[0]), .busy(busy_v[0]));

  present_iter_core #(.KEY_W(80), .ROUNDS(31), .SBOX_PAR(4)) u_dut_p4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_decrypt(in_decrypt), .key(key_bus[79:0]), .pt(pt_bus), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .ct(ct_a[1]), .busy(busy_v[1]));

  present_iter_core #(.KEY_W(128), .ROUNDS(31), .SBOX_PAR(16)) u_dut_k128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_decrypt(in_decrypt), .key(key_bus), .pt(pt_bus), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .ct(ct_a[2]), .busy(busy_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request to DUT sel and wait (bounded) for its result.
  task automatic run_op(input int sel, input logic dec, input logic [127:0] k,
                        input logic [63:0] p, output logic [63:0] res, output int lat);
    @(negedge clk);
    key_bus    = k;
    pt_bus     = p;
    in_decrypt = dec;
    in_valid_v = 3'(1 << sel);
    @(posedge clk); #1;
    in_valid_v = '0;
    lat = 0;
    while (!out_valid_v[sel] && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    res = ct_a[sel];
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [127:0] k;
    logic [63:0]  p;
    logic [63:0]  c;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [63:0] res;
    logic [63:0] res2;
    int          lat;
    logic [127:0] rk;
    logic [63:0]  rp;

    n_checks   = 0;
    n_fail     = 0;
    in_valid_v = '0;
    in_decrypt = 1'b0;
    out_ready  = 1'b0;
    key_bus    = '0;
    pt_bus     = '0;
    rst_n      = 1'b1;
    vecs[0] = '{K0,   P0, 64'h5579C1387B228445};
    vecs[1] = '{KF80, P0, 64'hE72C46C0F5945049};
    vecs[2] = '{K0,   PF, 64'hA112FFC72F68417B};
    vecs[3] = '{KF80, PF, 64'h3333DCD3213210D2};

    #2 rst_n = 1'b0;
    #10;
    check("rst_in_ready",  128'(in_ready_v),  128'(3'b111));
    check("rst_out_valid", 128'(out_valid_v), 128'(3'b000));
    check("rst_busy",      128'(busy_v),      128'(3'b000));
    check("rst_ct",        128'(ct_a[0]),     128'(0));
    @(negedge clk) rst_n = 1'b1;

    // Known-answer encryptions, 80-bit key, one round per cycle.
    for (int v = 0; v < 4; v++) begin
      run_op(0, 1'b0, vecs[v].k, vecs[v].p, res, lat);
      check($sformatf("enc80_ct_%0d", v), 128'(res), 128'(vecs[v].c));
      check($sformatf("enc80_lat_%0d", v), 128'(lat), 128'(31));
      take_result();
    end

    // Backpressure: result held, new requests ignored.
    run_op(0, 1'b0, K0, P0, res, lat);
    check("bp_ct", 128'(res), 128'(64'h5579C1387B228445));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid_v = 3'b001;
      key_bus    = KF80;
      pt_bus     = PF;
      @(posedge clk); #1;
      check("bp_hold_valid", 128'(out_valid_v[0]), 128'(1));
      check("bp_hold_ct",    128'(ct_a[0]),        128'(64'h5579C1387B228445));
      check("bp_in_ready",   128'(in_ready_v[0]),  128'(0));
    end
    in_valid_v = '0;
    take_result();
    check("bp_after_valid", 128'(out_valid_v[0]), 128'(0));
    check("bp_after_ready", 128'(in_ready_v[0]),  128'(1));
    check("bp_after_busy",  128'(busy_v[0]),      128'(0));
    run_op(0, 1'b0, KF80, P0, res, lat);
    check("bp_next_ct",  128'(res), 128'(64'hE72C46C0F5945049));
    check("bp_next_lat", 128'(lat), 128'(31));
    take_result();

    // Reset in the middle of an encryption.
    @(negedge clk);
    key_bus    = K0;
    pt_bus     = P0;
    in_decrypt = 1'b0;
    in_valid_v = 3'b001;
    @(posedge clk); #1;
    in_valid_v = '0;
    repeat (10) @(posedge clk);
    #2;
    check("mid_busy_pre", 128'(busy_v[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid_v[0]), 128'(0));
    check("mid_rst_ct",    128'(ct_a[0]),        128'(0));
    check("mid_rst_busy",  128'(busy_v[0]),      128'(0));
    check("mid_rst_ready", 128'(in_ready_v[0]),  128'(1));
    @(negedge clk) rst_n = 1'b1;
    run_op(0, 1'b0, KF80, PF, res, lat);
    check("post_rst_ct",  128'(res), 128'(64'h3333DCD3213210D2));
    check("post_rst_lat", 128'(lat), 128'(31));
    take_result();

    // Four S-boxes per cycle: same answer, four cycles per round.
    run_op(1, 1'b0, KF80, PF, res, lat);
    check("p4_ct",  128'(res), 128'(64'h3333DCD3213210D2));
    check("p4_lat", 128'(lat), 128'(124));
    take_result();

    // 128-bit key.
    run_op(2, 1'b0, K0, P0, res, lat);
    check("k128_ct",  128'(res), 128'(64'h96DB702A2E6900AF));
    check("k128_lat", 128'(lat), 128'(31));
    take_result();

`ifdef PRESENT_DECRYPT_EN
    run_op(0, 1'b1, K0, 64'h5579C1387B228445, res, lat);
    check("dec80_pt",  128'(res), 128'(P0));
    check("dec80_lat", 128'(lat), 128'(62));
    take_result();

    run_op(1, 1'b1, KF80, 64'h3333DCD3213210D2, res, lat);
    check("dec_p4_pt",  128'(res), 128'(PF));
    check("dec_p4_lat", 128'(lat), 128'(155));
    take_result();

    run_op(2, 1'b1, K0, 64'h96DB702A2E6900AF, res, lat);
    check("dec128_pt",  128'(res), 128'(P0));
    check("dec128_lat", 128'(lat), 128'(62));
    take_result();

    for (int t = 0; t < 4; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom};
      run_op(t % 3, 1'b0, rk, rp, res, lat);
      take_result();
      run_op(t % 3, 1'b1, rk, res, res2, lat);
      check($sformatf("roundtrip_%0d", t), 128'(res2), 128'(rp));
      take_result();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
